// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter feeding a one-entry registered output stage.
// A source may hold the grant for up to BURST consecutive words while the other waits.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x,
  output logic             x_ready,
  input  logic             y_valid,
  input  logic [WIDTH-1:0] y,
  output logic             y_ready,
  output logic             sel,
  output logic [WIDTH-1:0] output2,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned     CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  logic               last;
  logic [CNT_W-1:0]   cnt;

  logic               load_en;
  logic               winner;
  logic               xfer;

  // Arbitration: a lone requester wins; on a tie the last winner keeps the
  // grant until it has used up its burst allowance.
  always_comb begin
    load_en = (state == EMPTY) | out_ready;
    winner  = y_valid;
    if (x_valid && y_valid) begin
      winner = (cnt < BURST_C) ? last : ~last;
    end
    xfer = rst_n & load_en & (x_valid | y_valid);
  end

  assign x_ready   = xfer & ~winner;
  assign y_ready   = xfer & winner;
  assign sel       = xfer ? winner : last;
  assign out_valid = (state == FULL);

  // Output register, occupancy state and burst bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      output2 <= '0;
      out_src <= 1'b0;
      last    <= 1'b1;
      cnt     <= BURST_C;
    end else begin
      if (xfer) begin
        state <= FULL;
      end else if (out_ready) begin
        state <= EMPTY;
      end

      if (xfer) begin
        output2 <= sel ? y : x;
        out_src <= winner;
        if (winner == last) begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end else begin
          cnt  <= CNT_W'(1);
          last <= winner;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus random traffic against a
// run-length arbitration model and an in-order delivery scoreboard.
module tb_mux2_rr_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned BURST = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             x_valid;
  logic [WIDTH-1:0] x;
  logic             x_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y;
  logic             y_ready;
  logic             sel;
  logic [WIDTH-1:0] output2;
  logic             out_src;
  logic             out_valid;
  logic             out_ready;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             src;
  } item_t;

  // Reference model: occupancy, the source of the current grant run and its length.
  bit    m_full;
  bit    run_src;
  int    run_len;
  item_t sb[$];

  mux2_rr_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x(x), .x_ready(x_ready),
    .y_valid(y_valid), .y(y), .y_ready(y_ready),
    .sel(sel), .output2(output2), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; x_valid = 1'b0; y_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_full = 1'b0; run_src = 1'b1; run_len = BURST; sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x_valid = 1'b1; y_valid = 1'b1; out_ready = 1'b1; x = 4'h3; y = 4'h4;
    @(negedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (output2 !== 4'h0) begin miscompares++; $display("FAIL reset_output2: got %h want 0", output2); end
    vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL reset_out_src: got %b want 0", out_src); end
    vectors++; if (sel !== 1'b1) begin miscompares++; $display("FAIL reset_sel: got %b want 1", sel); end
    vectors++; if ({x_ready, y_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_readies: got %b want 00", {x_ready, y_ready}); end
  endtask

  task automatic test_single_x();
    do_reset();
    x_valid = 1'b1; x = 4'hA; out_ready = 1'b1;
    #1;
    vectors++; if ({x_ready, y_ready} !== 2'b10) begin miscompares++; $display("FAIL single_x_readies: got %b want 10", {x_ready, y_ready}); end
    vectors++; if (sel !== 1'b0) begin miscompares++; $display("FAIL single_x_sel: got %b want 0", sel); end
    @(posedge clk); #1;
    x_valid = 1'b0;
    vectors++; if (output2 !== 4'hA) begin miscompares++; $display("FAIL single_x_output2: got %h want a", output2); end
    vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL single_x_out_src: got %b want 0", out_src); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_x_out_valid: got %b want 1", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_tie_sequence();
    bit exp_src [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] exp_data;
    do_reset();
    x_valid = 1'b1; y_valid = 1'b1; x = 4'h1; y = 4'h2; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_data = exp_src[i] ? 4'h2 : 4'h1;
      vectors++; if (out_src !== exp_src[i]) begin miscompares++; $display("FAIL tie_out_src[%0d]: got %b want %b", i, out_src, exp_src[i]); end
      vectors++; if (output2 !== exp_data) begin miscompares++; $display("FAIL tie_output2[%0d]: got %h want %h", i, output2, exp_data); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    x_valid = 1'b1; x = 4'h5; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (output2 !== 4'h5) begin miscompares++; $display("FAIL bp_first_load: got %h want 5", output2); end
    out_ready = 1'b0; x = 4'h6; y_valid = 1'b1; y = 4'h7;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({x_ready, y_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_readies[%0d]: got %b want 00", i, {x_ready, y_ready}); end
      @(posedge clk); #1;
      vectors++; if ({out_valid, out_src, output2} !== {1'b1, 1'b0, 4'h5}) begin miscompares++; $display("FAIL bp_hold[%0d]: got %b/%b/%h want 1/0/5", i, out_valid, out_src, output2); end
    end
    out_ready = 1'b1;
    #1;
    vectors++; if ({x_ready, y_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_release_readies: got %b want 10", {x_ready, y_ready}); end
    @(posedge clk); #1;
    vectors++; if ({out_valid, out_src, output2} !== {1'b1, 1'b0, 4'h6}) begin miscompares++; $display("FAIL bp_drain_load: got %b/%b/%h want 1/0/6", out_valid, out_src, output2); end
    x_valid = 1'b0; y_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain_empty: got %b want 0", out_valid); end
    @(posedge clk); #1;
    vectors++; if ({out_src, output2} !== {1'b0, 4'h6}) begin miscompares++; $display("FAIL bp_empty_hold: got %b/%h want 0/6", out_src, output2); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int lens [2] = '{17, 20};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      y_valid = 1'b1; y = 4'h3; out_ready = 1'b1;
      for (int i = 0; i < lens[k]; i++) begin
        #1;
        vectors++; if (y_ready !== 1'b1) begin miscompares++; $display("FAIL sat_y_only[%0d]: got %b want 1", i, y_ready); end
        @(posedge clk);
      end
      #1;
      x_valid = 1'b1; x = 4'hC;
      #1;
      vectors++; if ({x_ready, y_ready, sel} !== 3'b100) begin miscompares++; $display("FAIL sat_first_tie_%0d: got %b want 100", lens[k], {x_ready, y_ready, sel}); end
      @(posedge clk); #1;
      vectors++; if ({out_src, output2} !== {1'b0, 4'hC}) begin miscompares++; $display("FAIL sat_tie_word_%0d: got %b/%h want 0/c", lens[k], out_src, output2); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    x_valid = 1'b1; x = 4'h9; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({out_valid, output2} !== {1'b1, 4'h9}) begin miscompares++; $display("FAIL arst_loaded: got %b/%h want 1/9", out_valid, output2); end
    y_valid = 1'b1; y = 4'hE; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({out_valid, output2, out_src} !== {1'b0, 4'h0, 1'b0}) begin miscompares++; $display("FAIL arst_immediate: got %b/%h/%b want 0/0/0", out_valid, output2, out_src); end
    out_ready = 1'b1;
    #1;
    vectors++; if ({x_ready, y_ready, sel} !== 3'b001) begin miscompares++; $display("FAIL arst_no_ready: got %b want 001", {x_ready, y_ready, sel}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One random-traffic cycle: check readies/outputs against the model, then advance it.
  task automatic rand_cycle(input bit drive_random);
    bit    exp_xfer;
    bit    exp_win;
    item_t exp_item;
    if (drive_random) begin
      x_valid = 1'($urandom_range(0, 1)); y_valid = 1'($urandom_range(0, 1));
      x = WIDTH'($urandom); y = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      x_valid = 1'b0; y_valid = 1'b0; out_ready = 1'b1;
    end
    #1;
    vectors++; if (out_valid !== m_full) begin miscompares++; $display("FAIL rand_out_valid: got %b want %b", out_valid, m_full); end
    if (m_full && out_ready) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++; $display("FAIL rand_sb_underflow: got delivery want none");
      end else begin
        exp_item = sb.pop_front();
        vectors++; if ({output2, out_src} !== exp_item) begin miscompares++; $display("FAIL rand_delivery: got %h/%b want %h/%b", output2, out_src, exp_item.data, exp_item.src); end
      end
    end
    exp_xfer = (!m_full || out_ready) && (x_valid || y_valid);
    if (x_valid && y_valid) exp_win = (run_len < BURST) ? run_src : !run_src;
    else                    exp_win = y_valid;
    vectors++; if ({x_ready, y_ready} !== {exp_xfer && !exp_win, exp_xfer && exp_win}) begin miscompares++; $display("FAIL rand_readies: got %b want %b", {x_ready, y_ready}, {exp_xfer && !exp_win, exp_xfer && exp_win}); end
    vectors++; if (x_ready && y_ready) begin miscompares++; $display("FAIL rand_two_readies: got 11 want at most one"); end
    if (exp_xfer) begin
      vectors++; if (sel !== exp_win) begin miscompares++; $display("FAIL rand_sel: got %b want %b", sel, exp_win); end
      sb.push_back({exp_win ? y : x, exp_win});
      if (exp_win == run_src) run_len = (run_len >= 15) ? 15 : run_len + 1;
      else begin run_src = exp_win; run_len = 1; end
      m_full = 1'b1;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) rand_cycle(1'b1);
    for (int i = 0; i < 2; i++) rand_cycle(1'b0);
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL rand_sb_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_x();
    test_tie_sequence();
    test_backpressure();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
